// File: rtl/usb_midi_audio_synth_keys_pkg.sv
// Shared register offsets and edge-capture encodings for the keys input PIO.
package usb_midi_audio_synth_keys_pkg;
   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_RSVD    = 2'd1;
   localparam logic [1:0] REG_IRQMASK = 2'd2;
   localparam logic [1:0] REG_EDGECAP = 2'd3;

   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;
endpackage

// File: rtl/usb_midi_audio_synth_keys_debounce.sv
// One key bit: 2-flop synchronizer, stable-count debouncer, previous level and edge strobe.
module usb_midi_audio_synth_keys_debounce
   import usb_midi_audio_synth_keys_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int EDGE_TYPE       = 1,
   parameter bit IDLE            = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic pin,
   output logic level,
   output logic hit
);
   localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   logic [1:0] sync;
   logic       stable;
   logic       prev;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync <= {2{IDLE}};
         prev <= IDLE;
      end else begin
         sync <= {sync[0], pin};
         prev <= stable;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign stable = sync[1];
      end else begin : g_db
         logic [CW-1:0] cnt;
         // Any return to the accepted level restarts the count, so short glitches never land.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               stable <= IDLE;
               cnt    <= '0;
            end else if (sync[1] == stable) begin
               cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               stable <= sync[1];
               cnt    <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end
      end
   endgenerate

   always_comb begin
      if (EDGE_TYPE == EDGE_RISING)       hit = stable & ~prev;
      else if (EDGE_TYPE == EDGE_FALLING) hit = ~stable & prev;
      else                                hit = stable ^ prev;
   end

   assign level = stable;
endmodule

// File: rtl/usb_midi_audio_synth_keys_pio.sv
// Avalon-MM input PIO for board keys: debounced DATA, IRQMASK, W1C EDGECAP and level irq.
module usb_midi_audio_synth_keys_pio
   import usb_midi_audio_synth_keys_pkg::*;
#(
   parameter int               WIDTH           = 4,
   parameter int               DEBOUNCE_CYCLES = 50000,
   parameter int               EDGE_TYPE       = 1,
   parameter logic [WIDTH-1:0] IDLE_LEVEL      = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             chipselect,
   input  logic [1:0]       address,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   logic [WIDTH-1:0] level;
   logic [WIDTH-1:0] hit;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] rd_mux;
   logic             wr_en;
   logic             unused_wd;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_key
         usb_midi_audio_synth_keys_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .EDGE_TYPE      (EDGE_TYPE),
            .IDLE           (IDLE_LEVEL[i])
         ) u_key (
            .clk    (clk),
            .reset_n(reset_n),
            .pin    (in_port[i]),
            .level  (level[i]),
            .hit    (hit[i])
         );
      end
   endgenerate

   assign wr_en     = chipselect & ~write_n;
   assign clr       = (wr_en && address == REG_EDGECAP) ? writedata[WIDTH-1:0] : '0;
   assign unused_wd = &{1'b0, writedata};

   always_comb begin
      rd_mux = '0;
      case (address)
         REG_DATA:    rd_mux = level;
         REG_IRQMASK: rd_mux = irq_mask;
         REG_EDGECAP: rd_mux = edge_cap;
         default:     rd_mux = '0;
      endcase
   end

   // A new edge in the same cycle as its clear keeps the bit set.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         edge_cap <= '0;
         readdata <= '0;
      end else begin
         if (wr_en && address == REG_IRQMASK) irq_mask <= writedata[WIDTH-1:0];
         edge_cap <= (edge_cap & ~clr) | hit;
         readdata <= 32'(rd_mux);
      end
   end

   assign irq = |(edge_cap & irq_mask);
endmodule
